// File: rtl/div_seq_ctrl_if.sv
// Bundle between the EX stage, the iterative divider and the HI/LO writer.
// Handshake rules: div_start is a level that stays high from the first BUSY
// cycle until div_ready is seen or div_annul pulses; div_ready is a one-cycle
// result-valid from the divider; hilo_we is a one-cycle write strobe whose
// data (hi_wdata/lo_wdata) is valid only while hilo_we is high.
interface div_seq_ctrl_if;
   logic        div_req;
   logic        div_sign;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        flush;
   logic        pipe_hold;
   logic        div_ready;
   logic [63:0] div_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_annul;
   logic        stall_div;
   logic        hilo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;
   logic        div_timeout;
   logic [1:0]  dbg_state;

   // Environment side: EX stage, divider and writeback.
   modport master (
      output div_req, div_sign, opa, opb, flush, pipe_hold, div_ready, div_result,
      input  div_start, div_signed, div_a, div_b, div_annul, stall_div,
             hilo_we, hi_wdata, lo_wdata, div_timeout, dbg_state
   );

   // Sequencer side.
   modport slave (
      input  div_req, div_sign, opa, opb, flush, pipe_hold, div_ready, div_result,
      output div_start, div_signed, div_a, div_b, div_annul, stall_div,
             hilo_we, hi_wdata, lo_wdata, div_timeout, dbg_state
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Divide sequencer: latches DIV/DIVU operands, runs the divider handshake,
// stalls EX until the result is ready and issues exactly one HI/LO write.
// Handles flush, divide-by-zero, downstream hold and a watchdog timeout.
module div_seq_ctrl #(
   parameter int DIV_TIMEOUT = 40
) (
   input logic            clk,
   input logic            rst,
   div_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] CNT_LAST = 6'(DIV_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [31:0] a_q, b_q, hi_q, lo_q;
   logic        sign_q;
   logic [5:0]  cnt_q;
   logic        timeout_q;

   logic        load_ops;
   logic        load_dz;
   logic        cap_res;
   logic        timeout_hit;
   logic        annul;

   // Next-state and control decode; flush/lost request beats ready beats timeout.
   always_comb begin
      state_nx    = state;
      load_ops    = 1'b0;
      load_dz     = 1'b0;
      cap_res     = 1'b0;
      timeout_hit = 1'b0;
      annul       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.div_req && !bus.flush) begin
               if (bus.opb != 32'd0) begin
                  load_ops = 1'b1;
                  state_nx = S_BUSY;
               end else begin
                  load_dz  = 1'b1;
                  state_nx = S_DONE;
               end
            end
         end
         S_BUSY: begin
            if (bus.flush || !bus.div_req) begin
               annul    = 1'b1;
               state_nx = S_IDLE;
            end else if (bus.div_ready) begin
               cap_res  = 1'b1;
               state_nx = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               annul       = 1'b1;
               timeout_hit = 1'b1;
               state_nx    = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.flush || !bus.pipe_hold) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand latch and saturating BUSY cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         sign_q <= 1'b0;
         cnt_q  <= 6'd0;
      end else if (load_ops) begin
         a_q    <= bus.opa;
         b_q    <= bus.opb;
         sign_q <= bus.div_sign;
         cnt_q  <= 6'd0;
      end else if (state == S_BUSY && cnt_q != 6'h3F) begin
         cnt_q  <= cnt_q + 6'd1;
      end
   end

   // HI/LO result registers: divider result, divide-by-zero pattern or zeros on timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (load_dz) begin
         hi_q <= bus.opa;
         lo_q <= 32'hFFFF_FFFF;
      end else if (cap_res) begin
         hi_q <= bus.div_result[63:32];
         lo_q <= bus.div_result[31:0];
      end else if (timeout_hit) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end
   end

   // Sticky watchdog flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (timeout_hit) begin
         timeout_q <= 1'b1;
      end
   end

   assign bus.div_start   = (state == S_BUSY);
   assign bus.div_signed  = sign_q;
   assign bus.div_a       = a_q;
   assign bus.div_b       = b_q;
   assign bus.div_annul   = annul;
   assign bus.stall_div   = bus.div_req && !bus.flush && (state == S_IDLE || state == S_BUSY);
   assign bus.hilo_we     = (state == S_DONE) && !bus.pipe_hold && !bus.flush;
   assign bus.hi_wdata    = hi_q;
   assign bus.lo_wdata    = lo_q;
   assign bus.div_timeout = timeout_q;
   assign bus.dbg_state   = state;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed divides with hand-computed HI/LO values,
// a behavioural divider handshake model and a scoreboard on hilo_we.
module tb_div_seq_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_seq_ctrl_if bus ();

   div_seq_ctrl #(.DIV_TIMEOUT(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- bookkeeping ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   int          n_stall, n_annul, n_start, n_we, annul_at;
   logic [31:0] exp_a, exp_b;
   logic        exp_sign;
   int          ready_lat = 0;
   int          busy_cnt  = 0;
   int          cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      n_stall  = 0;
      n_annul  = 0;
      n_start  = 0;
      n_we     = 0;
      annul_at = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_div_start"},   bus.div_start,   0);
      check({tag, "_div_signed"},  bus.div_signed,  0);
      check({tag, "_div_a"},       bus.div_a,       0);
      check({tag, "_div_b"},       bus.div_b,       0);
      check({tag, "_div_annul"},   bus.div_annul,   0);
      check({tag, "_stall_div"},   bus.stall_div,   0);
      check({tag, "_hilo_we"},     bus.hilo_we,     0);
      check({tag, "_hi_wdata"},    bus.hi_wdata,    0);
      check({tag, "_lo_wdata"},    bus.lo_wdata,    0);
      check({tag, "_div_timeout"}, bus.div_timeout, 0);
      check({tag, "_state"},       bus.dbg_state,   0);
   endtask

   // ---------------- divider model ----------------
   // Raises div_ready for one cycle in the ready_lat-th cycle of div_start.
   always @(posedge clk) begin
      #1;
      if (!bus.div_start) busy_cnt = 0;
      else                busy_cnt++;
      bus.div_ready = bus.div_start && (ready_lat != 0) && (busy_cnt == ready_lat);
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst) begin
         if (bus.stall_div) n_stall++;
         if (bus.div_start) begin
            n_start++;
            check("div_a_stable", bus.div_a, exp_a);
            check("div_b_stable", bus.div_b, exp_b);
            check("div_signed", bus.div_signed, exp_sign);
         end
         if (bus.div_annul) begin
            n_annul++;
            annul_at = n_start;
         end
         if (bus.hilo_we) begin
            n_we++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_write: got hi=0x%0h lo=0x%0h expected no write",
                        bus.hi_wdata, bus.lo_wdata);
            end else begin
               e = exp_q.pop_front();
               check("hilo_data", {bus.hi_wdata, bus.lo_wdata}, e);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Presents one request, scrambles opa/opb while BUSY, returns after the
   // cycle in which stall_div drops (the DONE cycle), at posedge+1.
   task automatic ex_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] res, input logic [63:0] exp,
                        output int stall_cycles);
      bus.div_req    = 1'b1;
      bus.div_sign   = sgn;
      bus.opa        = a;
      bus.opb        = b;
      bus.div_result = res;
      ready_lat      = lat;
      exp_a          = a;
      exp_b          = b;
      exp_sign       = sgn;
      exp_q.push_back(exp);
      stall_cycles   = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.stall_div) break;
         stall_cycles++;
         if (bus.dbg_state == 2'd1) begin
            bus.opa = $urandom;
            bus.opb = $urandom;
         end
         if (i == 199) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: stall_div still 1 after 200 cycles, expected release");
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- global watchdog ----------------
   initial begin
      #100000;
      $display("FAIL global_timeout: simulation ran past 100000 ns, expected completion");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      rst            = 1'b1;
      bus.div_req    = 1'b0;
      bus.div_sign   = 1'b0;
      bus.opa        = 32'd0;
      bus.opb        = 32'd0;
      bus.flush      = 1'b0;
      bus.pipe_hold  = 1'b0;
      bus.div_ready  = 1'b0;
      bus.div_result = 64'd0;
      exp_a = 0; exp_b = 0; exp_sign = 0;
      clear_counts();

      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Signed DIV -7 / 2: q=-3, r=-1; divider ready in BUSY cycle 33.
      clear_counts();
      ex_op(1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, cyc);
      bus.div_req = 1'b0;
      idle(3);
      check("sdiv_stall_cycles", cyc, 34);
      check("sdiv_stall_count", n_stall, 34);
      check("sdiv_start_cycles", n_start, 33);
      check("sdiv_writes", n_we, 1);
      check("sdiv_annul", n_annul, 0);
      check("sdiv_state_idle", bus.dbg_state, 0);

      // Divide by zero: DIVU 0x1234 / 0 -> hi=opa, lo=all ones, next cycle.
      clear_counts();
      ex_op(1'b0, 32'h0000_1234, 32'd0, 0, 64'd0, {32'h0000_1234, 32'hFFFF_FFFF}, cyc);
      bus.div_req = 1'b0;
      idle(3);
      check("dz_stall_cycles", cyc, 1);
      check("dz_start_never", n_start, 0);
      check("dz_writes", n_we, 1);

      // Flush in BUSY cycle 10: one annul pulse, no write.
      clear_counts();
      bus.div_req  = 1'b1;
      bus.div_sign = 1'b1;
      bus.opa      = 32'd50;
      bus.opb      = 32'd5;
      exp_a = 32'd50; exp_b = 32'd5; exp_sign = 1'b1;
      ready_lat    = 0;
      idle(10);
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_annul_now", bus.div_annul, 1);
      check("flush_stall_low", bus.stall_div, 0);
      @(posedge clk);
      #1;
      bus.flush   = 1'b0;
      bus.div_req = 1'b0;
      idle(3);
      check("flush_annul_count", n_annul, 1);
      check("flush_annul_cycle", annul_at, 10);
      check("flush_no_write", n_we, 0);
      check("flush_stall_count", n_stall, 10);
      check("flush_state_idle", bus.dbg_state, 0);

      // Hold in DONE for 3 cycles: DIVU 100 / 7 -> q=14, r=2.
      clear_counts();
      bus.div_req    = 1'b1;
      bus.div_sign   = 1'b0;
      bus.opa        = 32'd100;
      bus.opb        = 32'd7;
      bus.div_result = {32'd2, 32'd14};
      exp_a = 32'd100; exp_b = 32'd7; exp_sign = 1'b0;
      ready_lat      = 5;
      exp_q.push_back({32'd2, 32'd14});
      idle(5);
      bus.pipe_hold = 1'b1;
      idle(1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_no_we", bus.hilo_we, 0);
         check("hold_state_done", bus.dbg_state, 2);
         check("hold_data", {bus.hi_wdata, bus.lo_wdata}, {32'd2, 32'd14});
         @(posedge clk);
         #1;
      end
      bus.pipe_hold = 1'b0;
      @(negedge clk);
      check("hold_release_we", bus.hilo_we, 1);
      @(posedge clk);
      #1 bus.div_req = 1'b0;
      idle(3);
      check("hold_writes", n_we, 1);
      check("hold_state_idle", bus.dbg_state, 0);

      // Watchdog: divider never answers; abort in BUSY cycle 40 with hi=lo=0.
      clear_counts();
      ex_op(1'b1, 32'd5, 32'd3, 0, 64'h1, 64'd0, cyc);
      bus.div_req = 1'b0;
      idle(5);
      check("to_stall_cycles", cyc, 41);
      check("to_annul_count", n_annul, 1);
      check("to_annul_cycle", annul_at, 40);
      check("to_writes", n_we, 1);
      check("to_flag_sticky", bus.div_timeout, 1);

      // Async reset in BUSY cycle 5, then a normal DIV -100 / 7 -> q=-14, r=-2.
      clear_counts();
      bus.div_req  = 1'b1;
      bus.div_sign = 1'b1;
      bus.opa      = 32'd77;
      bus.opb      = 32'd3;
      exp_a = 32'd77; exp_b = 32'd3; exp_sign = 1'b1;
      ready_lat    = 0;
      repeat (5) @(posedge clk);
      #2;
      rst         = 1'b1;
      bus.div_req = 1'b0;
      @(negedge clk);
      check_outputs_zero("midrst");
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      clear_counts();
      ex_op(1'b1, 32'hFFFF_FF9C, 32'd7, 10, {32'hFFFF_FFFE, 32'hFFFF_FFF2},
            {32'hFFFF_FFFE, 32'hFFFF_FFF2}, cyc);
      bus.div_req = 1'b0;
      idle(3);
      check("post_rst_stall_cycles", cyc, 11);
      check("post_rst_writes", n_we, 1);

      // Back-to-back: DIVU 0xFFFFFFFF / 16, then DIVU 9 / 0 in the next IDLE cycle.
      clear_counts();
      ex_op(1'b0, 32'hFFFF_FFFF, 32'h10, 8, {32'h0000_000F, 32'h0FFF_FFFF},
            {32'h0000_000F, 32'h0FFF_FFFF}, cyc);
      check("b2b_first_stall", cyc, 9);
      ex_op(1'b0, 32'd9, 32'd0, 0, 64'd0, {32'd9, 32'hFFFF_FFFF}, cyc);
      bus.div_req = 1'b0;
      idle(3);
      check("b2b_second_stall", cyc, 1);
      check("b2b_writes", n_we, 2);

      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
